// File: rtl/range_accum_pkg.sv
// Shared types and constants for the sequential channel range accumulator.
// Holds the walker FSM state encoding and the operating-mode codes.
// Also provides a small helper to classify the mode field.
package range_accum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_SUM  = 2'b00;
  localparam logic [1:0] MODE_WRAP = 2'b01;
  localparam logic [1:0] MODE_MAX  = 2'b10;

  // Only the explicit max code selects max; 2'b11 behaves as a linear sum.
  function automatic logic is_max_mode(input logic [1:0] mode);
    return (mode == MODE_MAX);
  endfunction

endpackage

// File: rtl/range_bounds.sv
// Combinational range decoder: start channel and channel count for one request.
// Zero latency; purely combinational.
// No flow control; the caller samples the outputs when it accepts a request.
module range_bounds
  import range_accum_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int IDX_W = $clog2(N_CH)
) (
  input  logic [IDX_W-1:0] i_idx_a,
  input  logic [IDX_W-1:0] i_idx_b,
  input  logic [1:0]       i_mode,
  output logic [IDX_W-1:0] o_start,
  output logic [IDX_W:0]   o_len
);

  logic [IDX_W-1:0] w_lo;
  logic [IDX_W-1:0] w_hi;
  logic [IDX_W-1:0] w_span;

  // Order the two indices for the linear modes.
  always_comb begin
    w_lo = i_idx_a;
    w_hi = i_idx_b;
    if (i_idx_b < i_idx_a) begin
      w_lo = i_idx_b;
      w_hi = i_idx_a;
    end
  end

  // Wrap walks a..b upward; the IDX_W-bit subtraction is already modulo N_CH
  // because N_CH is a power of two, so b == a-1 yields a span of N_CH-1.
  always_comb begin
    o_start = w_lo;
    w_span  = w_hi - w_lo;
    if (i_mode == MODE_WRAP) begin
      o_start = i_idx_a;
      w_span  = i_idx_b - i_idx_a;
    end
    o_len = {1'b0, w_span} + (IDX_W+1)'(1);
  end

endmodule

// File: rtl/range_accum_seq.sv
// Walks a latched range of channels one per clock, accumulating sum or max.
// Latency L+1 cycles from accept to the one-cycle done pulse (L = channels walked).
// start is taken only in IDLE and never queued; clr aborts any state at once.
module range_accum_seq
  import range_accum_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int W     = 4,
  parameter int IDX_W = $clog2(N_CH),
  parameter int SUM_W = W + IDX_W + 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_clr,
  input  logic                i_start,
  input  logic [N_CH*W-1:0]   i_din,
  input  logic [IDX_W-1:0]    i_idx_a,
  input  logic [IDX_W-1:0]    i_idx_b,
  input  logic [1:0]          i_mode,
  output logic                o_busy,
  output logic                o_done,
  output logic [SUM_W-1:0]    o_result,
  output logic [IDX_W:0]      o_count
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [N_CH*W-1:0]   r_din;
  logic [IDX_W-1:0]    r_ptr;
  logic [IDX_W:0]      r_remain;
  logic [IDX_W:0]      r_len;
  logic                r_is_max;
  logic [SUM_W-1:0]    r_acc;
  logic [SUM_W-1:0]    r_result;
  logic [IDX_W:0]      r_count;

  logic [IDX_W-1:0]    w_bnd_start;
  logic [IDX_W:0]      w_bnd_len;
  logic                w_accept;
  logic                w_last;
  logic [W-1:0]        w_ch;
  logic [SUM_W-1:0]    w_ch_ext;
  logic [SUM_W-1:0]    w_acc_nxt;

  range_bounds #(
    .N_CH  (N_CH),
    .IDX_W (IDX_W)
  ) u_bounds (
    .i_idx_a (i_idx_a),
    .i_idx_b (i_idx_b),
    .i_mode  (i_mode),
    .o_start (w_bnd_start),
    .o_len   (w_bnd_len)
  );

  assign w_accept = (r_state == ST_IDLE) && i_start && !i_clr;
  assign w_last   = (r_remain == (IDX_W+1)'(1));
  assign w_ch     = r_din[W*r_ptr +: W];
  assign w_ch_ext = {{(SUM_W-W){1'b0}}, w_ch};

  // Next accumulator value for the channel under the pointer.
  always_comb begin
    w_acc_nxt = r_acc + w_ch_ext;
    if (r_is_max) begin
      w_acc_nxt = (w_ch_ext > r_acc) ? w_ch_ext : r_acc;
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; clr overrides every transition.
  always_comb begin
    w_state_nxt = r_state;
    if (i_clr) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (i_start) w_state_nxt = ST_RUN;
        ST_RUN:  if (w_last)  w_state_nxt = ST_DONE;
        ST_DONE: w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Status outputs decoded from the current state.
  always_comb begin
    o_busy = (r_state == ST_RUN);
    o_done = (r_state == ST_DONE);
  end

  // Datapath: latch the request on accept, walk the range, publish on the last channel.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_din    <= '0;
      r_ptr    <= '0;
      r_remain <= '0;
      r_len    <= '0;
      r_is_max <= 1'b0;
      r_acc    <= '0;
      r_result <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_ptr    <= '0;
      r_remain <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_count  <= '0;
    end else if (w_accept) begin
      r_din    <= i_din;
      r_ptr    <= w_bnd_start;
      r_remain <= w_bnd_len;
      r_len    <= w_bnd_len;
      r_is_max <= is_max_mode(i_mode);
      r_acc    <= '0;
    end else if (r_state == ST_RUN) begin
      r_acc    <= w_acc_nxt;
      r_ptr    <= r_ptr + IDX_W'(1);
      r_remain <= r_remain - (IDX_W+1)'(1);
      // The result register is loaded on the edge into DONE so it is valid
      // in the same cycle as the done pulse.
      if (w_last) begin
        r_result <= w_acc_nxt;
        r_count  <= r_len;
      end
    end
  end

  assign o_result = r_result;
  assign o_count  = r_count;

endmodule

// File: tb/tb_range_accum_seq.sv
// Self-checking bench for range_accum_seq with default parameters.
// Table vectors, hand-written abort/ignore sequences, then random operations.
// Expected values come from a queue-based range model.
module tb_range_accum_seq;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_clr;
  logic        i_start;
  logic [31:0] i_din;
  logic [2:0]  i_idx_a;
  logic [2:0]  i_idx_b;
  logic [1:0]  i_mode;
  logic        o_busy;
  logic        o_done;
  logic [7:0]  o_result;
  logic [3:0]  o_count;

  int n_tests = 0;
  int n_fail  = 0;

  range_accum_seq dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (i_clr),
    .i_start  (i_start),
    .i_din    (i_din),
    .i_idx_a  (i_idx_a),
    .i_idx_b  (i_idx_b),
    .i_mode   (i_mode),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_result (o_result),
    .o_count  (o_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] d;
    int          a;
    int          b;
    logic [1:0]  m;
    int          res;
    int          cnt;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: list the selected channel indices, then reduce them.
  function automatic void model(input logic [31:0] d, input int a, input int b,
                                input logic [1:0] m, output int res, output int len);
    int q[$];
    int j;
    int lo;
    int hi;
    if (m == 2'b01) begin
      j = a;
      q.push_back(j);
      while (j != b) begin
        j = (j + 1) % 8;
        q.push_back(j);
      end
    end else begin
      lo = (a < b) ? a : b;
      hi = (a < b) ? b : a;
      for (int k = lo; k <= hi; k++) q.push_back(k);
    end
    res = 0;
    foreach (q[i]) begin
      int v;
      v = int'((d >> (4 * q[i])) & 32'hF);
      if (m == 2'b10) res = (v > res) ? v : res;
      else            res = res + v;
    end
    len = q.size();
  endfunction

  // One full operation; inj_cyc > 0 pulses a competing start in that RUN cycle.
  task automatic do_op(input string nm, input logic [31:0] d, input int a, input int b,
                       input logic [1:0] m, input int exp_res, input int exp_cnt,
                       input int inj_cyc);
    int  cyc;
    bit  got;
    bit  busy_ok;
    @(negedge i_clk);
    i_din   = d;
    i_idx_a = a[2:0];
    i_idx_b = b[2:0];
    i_mode  = m;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    // Inputs changing after accept must not matter.
    i_din   = $urandom;
    i_idx_a = 3'($urandom_range(0, 7));
    i_idx_b = 3'($urandom_range(0, 7));
    i_mode  = 2'($urandom_range(0, 3));
    cyc = 0;
    got = 0;
    busy_ok = 1;
    while (!got && cyc < 40) begin
      @(negedge i_clk);
      cyc++;
      i_start = (cyc == inj_cyc);
      if (o_done) got = 1;
      else if (!o_busy) busy_ok = 0;
    end
    i_start = 1'b0;
    check({nm, " done_seen"}, int'(got), 1);
    check({nm, " done_cycle"}, cyc, exp_cnt + 1);
    check({nm, " busy_during_run"}, int'(busy_ok), 1);
    check({nm, " busy_at_done"}, int'(o_busy), 0);
    check({nm, " result"}, int'(o_result), exp_res);
    check({nm, " count"}, int'(o_count), exp_cnt);
    @(negedge i_clk);
    check({nm, " done_one_cycle"}, int'(o_done), 0);
    check({nm, " result_held"}, int'(o_result), exp_res);
  endtask

  // Watch a window where nothing must be running or completing.
  task automatic expect_quiet(input string nm, input int cycles);
    bit bad;
    bad = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge i_clk);
      if (o_done || o_busy) bad = 1;
    end
    check({nm, " quiet"}, int'(bad), 0);
  endtask

  task automatic start_and_wait(input logic [31:0] d, input int a, input int b,
                                input logic [1:0] m, input int n_cyc);
    @(negedge i_clk);
    i_din   = d;
    i_idx_a = a[2:0];
    i_idx_b = b[2:0];
    i_mode  = m;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    for (int k = 0; k < n_cyc; k++) @(negedge i_clk);
  endtask

  initial begin
    int r_res;
    int r_len;
    logic [31:0] rd;
    int ra;
    int rb;
    logic [1:0] rm;

    tbl[0] = '{32'h87654321, 5, 2, 2'b00, 18, 4};
    tbl[1] = '{32'h87654321, 6, 0, 2'b01, 16, 3};
    tbl[2] = '{32'hFFFFFFFF, 3, 2, 2'b01, 120, 8};
    tbl[3] = '{32'h87654321, 3, 3, 2'b00, 4, 1};
    tbl[4] = '{32'h87654321, 3, 3, 2'b11, 4, 1};
    tbl[5] = '{32'h1F2E3D4C, 1, 5, 2'b10, 14, 5};
    tbl[6] = '{32'h87654321, 3, 3, 2'b01, 4, 1};

    i_rst_n = 1'b0;
    i_clr   = 1'b0;
    i_start = 1'b0;
    i_din   = '0;
    i_idx_a = '0;
    i_idx_b = '0;
    i_mode  = '0;
    #12;
    check("reset busy", int'(o_busy), 0);
    check("reset done", int'(o_done), 0);
    check("reset result", int'(o_result), 0);
    check("reset count", int'(o_count), 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    for (int t = 0; t < 7; t++) begin
      do_op($sformatf("vec%0d", t), tbl[t].d, tbl[t].a, tbl[t].b, tbl[t].m,
            tbl[t].res, tbl[t].cnt, 0);
    end

    // Second start at cycle 3 while running is dropped.
    do_op("start_ignored", 32'h87654321, 0, 7, 2'b00, 36, 8, 3);
    expect_quiet("no_queued_start", 12);

    // clr at cycle 2 aborts.
    start_and_wait(32'h87654321, 0, 7, 2'b00, 2);
    i_clr = 1'b1;
    @(posedge i_clk);
    #1;
    i_clr = 1'b0;
    @(negedge i_clk);
    check("clr busy", int'(o_busy), 0);
    check("clr result", int'(o_result), 0);
    check("clr count", int'(o_count), 0);
    expect_quiet("after_clr", 12);
    do_op("after_clr_op", 32'h87654321, 6, 0, 2'b01, 16, 3, 0);

    // Asynchronous reset mid-run.
    start_and_wait(32'h87654321, 0, 7, 2'b00, 2);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("arst busy", int'(o_busy), 0);
    check("arst done", int'(o_done), 0);
    check("arst result", int'(o_result), 0);
    check("arst count", int'(o_count), 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    expect_quiet("after_arst", 12);
    do_op("after_arst_op", 32'h87654321, 5, 2, 2'b00, 18, 4, 0);

    // clr and start together in IDLE: nothing accepted.
    @(negedge i_clk);
    i_din   = 32'h87654321;
    i_idx_a = 3'd0;
    i_idx_b = 3'd7;
    i_mode  = 2'b00;
    i_start = 1'b1;
    i_clr   = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    i_clr   = 1'b0;
    check("clr_start result", int'(o_result), 0);
    expect_quiet("clr_start", 12);

    for (int t = 0; t < 40; t++) begin
      rd = $urandom;
      ra = $urandom_range(0, 7);
      rb = $urandom_range(0, 7);
      rm = 2'($urandom_range(0, 3));
      model(rd, ra, rb, rm, r_res, r_len);
      do_op($sformatf("rand%0d", t), rd, ra, rb, rm, r_res, r_len, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/range_accum_seq.md
# range_accum_seq

Sequential, parametrised successor to the combinational nibble range summer. It latches a packed vector of `N_CH` unsigned `W`-bit channels and a pair of channel indices on a `start` handshake. It then walks the selected channels one per clock, accumulating either their sum or their maximum, and presents the result with a one-cycle `done` pulse. The block sits behind the switch/button front end and feeds the display path.

## Interface
- `N_CH`, default 8: number of channels, power of two, at least 2.
- `W`, default 4: width of each channel.
- `IDX_W`, default `$clog2(N_CH)`: channel index width (derived).
- `SUM_W`, default `W+IDX_W+1`: result width (derived). A full-range sum never overflows.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `clr` input 1: synchronous abort/clear; takes priority over `start`.
- `start` input 1: request; accepted only in IDLE.
- `din` input `N_CH*W`: channel j occupies bits `[W*j+W-1 : W*j]`.
- `idx_a` input `IDX_W`: first index.
- `idx_b` input `IDX_W`: second index.
- `mode` input 2: 00 linear sum, 01 wrap sum, 10 linear max, 11 treated as 00.
- `busy` output 1: high while walking channels.
- `done` output 1: one-cycle pulse when the result updates.
- `result` output `SUM_W`: sum or max, held until the next accept or clear.
- `count` output `IDX_W+1`: number of channels processed in the last operation.

## Operation
- Linear range (modes 00 and 10):
  - lo = min(idx_a, idx_b), hi = max(idx_a, idx_b); channels lo..hi inclusive.
  - idx_a == idx_b selects the single channel.
- Wrap range (mode 01):
  - Walk upward from idx_a to idx_b modulo `N_CH`, inclusive.
  - idx_a > idx_b crosses channel N_CH-1 → 0.
  - idx_b == idx_a-1 (mod N_CH) selects all `N_CH` channels.
  - idx_a == idx_b selects one channel.
- Length L = number of selected channels, from 1 to `N_CH`.
- Accept: in IDLE with `start`=1 and `clr`=0, latch `din`, the start pointer, L and mode, and clear the accumulator to 0.
- Accumulate:
  - Sum: acc += ch[ptr], zero-extended to `SUM_W`.
  - Max: acc = max(acc, ch[ptr]), unsigned.
- Pointer increments modulo `N_CH` each RUN cycle.
- FSM:
  - IDLE → RUN on accept.
  - RUN stays for L cycles, one channel per cycle, then → DONE.
  - DONE → IDLE unconditionally after one cycle.
- In DONE: `result` ← acc, `count` ← L, `done`=1.
- `start` in RUN or DONE is ignored, not queued.
- `din`, `idx_*` and `mode` changes after accept have no effect.
- `clr` in any state: next state IDLE, `result`=0, `count`=0, `busy`=0, no `done` pulse.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, `count`=0, state IDLE, accumulator 0.
- Accept edge at cycle 0. `busy`=1 during cycles 1..L.
- `done`=1 and `result`/`count` valid in cycle L+1, with `busy`=0 there. Latency is L+1 cycles.
- Earliest next accept is the cycle after `done`, at L+2.
- `rst_n` low mid-operation clears everything asynchronously. No `done` follows.
- `clr` and `start` in the same IDLE cycle: `clr` wins, nothing is accepted.

## Structure
- Package `range_accum_pkg`:
  - State enum IDLE/RUN/DONE.
  - Mode constants MODE_SUM, MODE_WRAP, MODE_MAX.
- Sub-module `range_bounds` (combinational): from idx_a, idx_b and mode, produce the start pointer and L (`IDX_W+1` bits).
- Top holds the FSM, pointer, down-counter, channel mux and accumulator.

## Test plan
Defaults N_CH=8, W=4, din=32'h87654321 (ch0=1 … ch7=8) unless stated.
- Linear sum, mode 00, a=5, b=2 → result 18, count 4, `done` at cycle 5, `busy` cycles 1–4.
- Wrap sum, mode 01, a=6, b=0 → channels 6, 7, 0, result 16, count 3. With a=3, b=2 and din=32'hFFFFFFFF → result 120, count 8, `done` at cycle 9.
- Single channel, mode 00, a=b=3 → result 4, count 1, `done` at cycle 2. Mode 11, same indices → identical result.
- Linear max, mode 10, din=32'h1F2E3D4C, a=1, b=5 → result 14, count 5.
- `start` with a=0, b=7, then `start` with new values at cycle 3 → ignored, result 36.
- Abort cases:
  - `clr` at cycle 2 → IDLE, result 0, no `done`.
  - `rst_n` low mid-RUN → all outputs 0 immediately.
  - A fresh start after either → correct result.
